// File: rtl/encode_pkg.sv
// Shared defaults and quadrature step encoding for the encoder sample generator.
// Contents: default period/width constants, step_e enum, quad_pos/quad_step helpers.
package encode_pkg;

  localparam int unsigned UNIT_INTER_DEF      = 4000;
  localparam int unsigned ENCODE_WID_DEF      = 32;
  localparam int unsigned ENCODE_MASK_WID_DEF = 32;

  // Encoding equals the Gray-position difference (cur - prev) mod 4.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_ERR  = 2'b10,
    STEP_REV  = 2'b11
  } step_e;

  // Position of an {a,b} level on the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // A two-position jump means both lines moved in one cycle: illegal.
  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    diff = quad_pos(cur) - quad_pos(prev);
    return step_e'(diff);
  endfunction

endpackage

// File: rtl/encode_sample_gen_if.sv
// Sample output bus of encode_sample_gen.
// Signals: encode_update_o strobe, encode_w_o / encode_x_o samples,
//          x_zero_flag_o home pulse, w_quad_err_o / x_quad_err_o sticky errors.
interface encode_sample_gen_if
  import encode_pkg::*;
#(
  parameter int unsigned ENCODE_WID = ENCODE_WID_DEF
);

  logic                  encode_update_o;
  logic [ENCODE_WID-1:0] encode_w_o;
  logic [ENCODE_WID-1:0] encode_x_o;
  logic                  x_zero_flag_o;
  logic                  w_quad_err_o;
  logic                  x_quad_err_o;

  modport master (
    output encode_update_o, encode_w_o, encode_x_o,
    output x_zero_flag_o, w_quad_err_o, x_quad_err_o
  );

  modport slave (
    input encode_update_o, encode_w_o, encode_x_o,
    input x_zero_flag_o, w_quad_err_o, x_quad_err_o
  );

endinterface

// File: rtl/quad_decoder.sv
// 4x quadrature decoder with input synchronisers and index edge detect.
// Ports: clk_i, rst_i; a, b, idx asynchronous inputs;
//        step_c (combinational step for the next count update),
//        idx_rise_c (synchronised index rising edge), err (sticky illegal transition).
module quad_decoder
  import encode_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  a,
  input  logic  b,
  input  logic  idx,
  output step_e step_c,
  output logic  idx_rise_c,
  output logic  err
);

  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [SYNC_STAGES-1:0] idx_sync;
  logic [1:0]             ab_prev;
  logic                   idx_prev;
  logic                   primed;
  logic [1:0]             ab_cur;
  step_e                  raw_step;

  // Synchronisers, previous state and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sync   <= '0;
      b_sync   <= '0;
      idx_sync <= '0;
      ab_prev  <= 2'b00;
      idx_prev <= 1'b0;
      primed   <= 1'b0;
      err      <= 1'b0;
    end else begin
      a_sync   <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync   <= {b_sync[SYNC_STAGES-2:0], b};
      idx_sync <= {idx_sync[SYNC_STAGES-2:0], idx};
      ab_prev  <= ab_cur;
      idx_prev <= idx_sync[SYNC_STAGES-1];
      primed   <= 1'b1;
      if (primed && (raw_step == STEP_ERR)) begin
        err <= 1'b1;
      end
    end
  end

  // First cycle after reset only captures the level, never counts.
  always_comb begin
    ab_cur     = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
    raw_step   = quad_step(ab_prev, ab_cur);
    step_c     = primed ? raw_step : STEP_NONE;
    idx_rise_c = idx_sync[SYNC_STAGES-1] & ~idx_prev;
  end

endmodule

// File: rtl/encode_sample_gen.sv
// Periodic sampler of a rotary (W) and a linear (X) quadrature encoder.
// Ports: clk_i, rst_i (sync, active-high), enable_i; w_a_i/w_b_i/w_z_i and
//        x_a_i/x_b_i/x_home_i asynchronous encoder inputs; smp sample bus (master).
module encode_sample_gen
  import encode_pkg::*;
#(
  parameter real         TCQ             = 0.1,
  parameter int unsigned UNIT_INTER      = UNIT_INTER_DEF,
  parameter int unsigned ENCODE_MASK_WID = ENCODE_MASK_WID_DEF,
  parameter int unsigned ENCODE_WID      = ENCODE_WID_DEF,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                w_a_i,
  input  logic                w_b_i,
  input  logic                w_z_i,
  input  logic                x_a_i,
  input  logic                x_b_i,
  input  logic                x_home_i,
  encode_sample_gen_if.master smp
);

  localparam int unsigned PER_WID = (UNIT_INTER > 1) ? $clog2(UNIT_INTER) : 1;
  localparam logic [PER_WID-1:0]         PER_LAST = PER_WID'(UNIT_INTER - 1);
  localparam logic [PER_WID-1:0]         PER_ONE  = PER_WID'(1);
  localparam logic [ENCODE_MASK_WID-1:0] W_ONE    = ENCODE_MASK_WID'(1);
  localparam logic [ENCODE_WID-1:0]      X_ONE    = ENCODE_WID'(1);

  // TCQ is a simulation-only delay; it is range-checked but never applied.
  if (SYNC_STAGES < 2 || ENCODE_WID < ENCODE_MASK_WID || UNIT_INTER < 1 || TCQ < 0.0) begin : g_bad_param
    $error("encode_sample_gen: illegal parameter combination");
  end

  step_e                      w_step;
  step_e                      x_step;
  logic                       w_idx_rise;
  logic                       x_home_rise;
  logic                       w_err;
  logic                       x_err;
  logic [ENCODE_MASK_WID-1:0] w_cnt;
  logic [ENCODE_WID-1:0]      x_cnt;
  logic [PER_WID-1:0]         per_cnt;
  logic                       en_q;
  logic                       run_c;

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_w_dec (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a          (w_a_i),
    .b          (w_b_i),
    .idx        (w_z_i),
    .step_c     (w_step),
    .idx_rise_c (w_idx_rise),
    .err        (w_err)
  );

  quad_decoder #(.SYNC_STAGES(SYNC_STAGES)) u_x_dec (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a          (x_a_i),
    .b          (x_b_i),
    .idx        (x_home_i),
    .step_c     (x_step),
    .idx_rise_c (x_home_rise),
    .err        (x_err)
  );

  // Position counters; index/home beats a same-cycle step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_cnt <= '0;
      x_cnt <= '0;
    end else begin
      if (w_idx_rise)                w_cnt <= '0;
      else if (w_step == STEP_FWD)   w_cnt <= w_cnt + W_ONE;
      else if (w_step == STEP_REV)   w_cnt <= w_cnt - W_ONE;

      if (x_home_rise)               x_cnt <= '0;
      else if (x_step == STEP_FWD)   x_cnt <= x_cnt + X_ONE;
      else if (x_step == STEP_REV)   x_cnt <= x_cnt - X_ONE;
    end
  end

  // Period runs one cycle after enable is seen, so the first strobe lands UNIT_INTER+1 later.
  always_comb begin
    run_c = enable_i & en_q;
  end

  // Period counter and sample latch; latch takes the pre-update counter values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q                <= 1'b0;
      per_cnt             <= '0;
      smp.encode_update_o <= 1'b0;
      smp.encode_w_o      <= '0;
      smp.encode_x_o      <= '0;
      smp.x_zero_flag_o   <= 1'b0;
    end else begin
      en_q                <= enable_i;
      smp.encode_update_o <= 1'b0;
      smp.x_zero_flag_o   <= x_home_rise;
      if (!run_c) begin
        per_cnt <= '0;
      end else if (per_cnt == PER_LAST) begin
        per_cnt             <= '0;
        smp.encode_update_o <= 1'b1;
        smp.encode_w_o      <= ENCODE_WID'(w_cnt);
        smp.encode_x_o      <= x_cnt;
      end else begin
        per_cnt <= per_cnt + PER_ONE;
      end
    end
  end

  assign smp.w_quad_err_o = w_err;
  assign smp.x_quad_err_o = x_err;

endmodule

// File: tb/tb_encode_sample_gen.sv
// Directed self-checking bench for encode_sample_gen (default parameters).
module tb_encode_sample_gen;

  localparam int unsigned UNIT = 4000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic w_a = 1'b0, w_b = 1'b0, w_z = 1'b0;
  logic x_a = 1'b0, x_b = 1'b0, x_home = 1'b0;

  int errors = 0;
  int checks = 0;
  int w_pos = 0;
  int x_pos = 0;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  encode_sample_gen_if #(.ENCODE_WID(32)) smp ();

  encode_sample_gen dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .w_a_i    (w_a),
    .w_b_i    (w_b),
    .w_z_i    (w_z),
    .x_a_i    (x_a),
    .x_b_i    (x_b),
    .x_home_i (x_home),
    .smp      (smp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic w_move(input int n, input bit fwd);
    repeat (n) begin
      w_pos = fwd ? (w_pos + 1) % 4 : (w_pos + 3) % 4;
      {w_a, w_b} = gray[w_pos];
      tick(4);
    end
  endtask

  task automatic x_move(input int n, input bit fwd);
    repeat (n) begin
      x_pos = fwd ? (x_pos + 1) % 4 : (x_pos + 3) % 4;
      {x_a, x_b} = gray[x_pos];
      tick(4);
    end
  endtask

  task automatic wait_strobe(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < UNIT + 8 && !seen; k++) begin
      @(negedge clk);
      if (smp.encode_update_o === 1'b1) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int h0, h1, nh, flags;
    logic [31:0] w_first;

    // Reset
    tick(4);
    rst = 1'b0;
    tick(1);
    chk("rst_update", 64'(smp.encode_update_o), 64'd0);
    chk("rst_w",      64'(smp.encode_w_o),      64'd0);
    chk("rst_x",      64'(smp.encode_x_o),      64'd0);
    chk("rst_zflag",  64'(smp.x_zero_flag_o),   64'd0);
    chk("rst_werr",   64'(smp.w_quad_err_o),    64'd0);
    chk("rst_xerr",   64'(smp.x_quad_err_o),    64'd0);

    // Idle: no strobes while disabled
    nh = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (smp.encode_update_o === 1'b1) nh++;
    end
    chk("idle_no_strobe", 64'(nh), 64'd0);

    // Enable rise: strobes at T+4001 and T+8001
    enable = 1'b1;
    h0 = 0; h1 = 0; nh = 0; w_first = 32'hDEAD_BEEF;
    for (int k = 1; k <= 8002; k++) begin
      @(negedge clk);
      if (smp.encode_update_o === 1'b1) begin
        if (nh == 0) begin h0 = k; w_first = smp.encode_w_o; end
        else if (nh == 1) h1 = k;
        nh++;
      end
    end
    chk("en_strobe_count", 64'(nh), 64'd2);
    chk("en_first_strobe", 64'(h0), 64'd4001);
    chk("en_second_strobe", 64'(h1), 64'd8001);
    chk("en_first_w", 64'(w_first), 64'd0);

    // 8 forward W edges
    w_move(8, 1'b1);
    wait_strobe("w8_strobe");
    chk("w8_w",    64'(smp.encode_w_o),   64'd8);
    chk("w8_werr", 64'(smp.w_quad_err_o), 64'd0);
    chk("w8_x",    64'(smp.encode_x_o),   64'd0);

    // Index together with a forward step: index wins
    w_z = 1'b1;
    w_move(1, 1'b1);
    w_z = 1'b0;
    tick(4);
    wait_strobe("widx_strobe");
    chk("widx_w", 64'(smp.encode_w_o), 64'd0);

    // Wrap below zero and back
    w_move(1, 1'b0);
    wait_strobe("wrev_strobe");
    chk("wrev_w", 64'(smp.encode_w_o), 64'hFFFF_FFFF);
    w_move(1, 1'b1);
    wait_strobe("wfwd_strobe");
    chk("wfwd_w", 64'(smp.encode_w_o), 64'd0);

    // 5 reverse X steps
    x_move(5, 1'b0);
    wait_strobe("x5_strobe");
    chk("x5_x", 64'(smp.encode_x_o), 64'hFFFF_FFFB);

    // Home edge coinciding with the sample latch
    flags = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (smp.x_zero_flag_o === 1'b1) flags++;
      if (k == 3997) x_home = 1'b1;
    end
    chk("home_update", 64'(smp.encode_update_o), 64'd1);
    chk("home_x_preclear", 64'(smp.encode_x_o), 64'hFFFF_FFFB);
    chk("home_zflag", 64'(smp.x_zero_flag_o), 64'd1);
    x_home = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (smp.x_zero_flag_o === 1'b1) flags++;
    end
    chk("home_zflag_pulses", 64'(flags), 64'd1);
    wait_strobe("home_next_strobe");
    chk("home_next_x", 64'(smp.encode_x_o), 64'd0);

    // Illegal X transitions, W returns to 00
    w_move(3, 1'b1);
    x_move(1, 1'b1);
    {x_a, x_b} = 2'b11;
    tick(4);
    chk("xerr_set", 64'(smp.x_quad_err_o), 64'd1);
    {x_a, x_b} = 2'b00;
    tick(4);
    wait_strobe("xerr_strobe");
    chk("xerr_x",    64'(smp.encode_x_o),   64'd1);
    chk("xerr_w",    64'(smp.encode_w_o),   64'd3);
    chk("xerr_held", 64'(smp.x_quad_err_o), 64'd1);
    chk("xerr_werr", 64'(smp.w_quad_err_o), 64'd0);

    // Reset at period count 3999
    for (int k = 1; k <= 3999; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_update", 64'(smp.encode_update_o), 64'd0);
    chk("mrst_w",      64'(smp.encode_w_o),      64'd0);
    chk("mrst_x",      64'(smp.encode_x_o),      64'd0);
    chk("mrst_zflag",  64'(smp.x_zero_flag_o),   64'd0);
    chk("mrst_xerr",   64'(smp.x_quad_err_o),    64'd0);
    chk("mrst_werr",   64'(smp.w_quad_err_o),    64'd0);
    rst = 1'b0;
    h0 = 0;
    for (int k = 1; k <= 4005; k++) begin
      @(negedge clk);
      if (smp.encode_update_o === 1'b1 && h0 == 0) h0 = k;
    end
    chk("mrst_restart_strobe", 64'(h0), 64'd4001);
    chk("mrst_restart_w", 64'(smp.encode_w_o), 64'd0);
    chk("mrst_restart_x", 64'(smp.encode_x_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
